// File: rtl/psu_maskacc.sv
// psu_maskacc: sweeps every psu_maskext demux slot, OR-accumulates the per-qubit masks, hands them off valid/ready.
// Define PSU_MASKACC_COLLISION_EN to build the sticky overlap detector on collision.
`ifndef NUM_UCDMX_OUT
`define NUM_UCDMX_OUT 2
`endif
`ifndef NUM_QBDMX_OUT
`define NUM_QBDMX_OUT 3
`endif
`ifndef NUM_UCC
`define NUM_UCC 2
`endif
`ifndef UCADDR_BW
`define UCADDR_BW 4
`endif
`ifndef NUM_QBCTRL
`define NUM_QBCTRL 2
`endif
`ifndef QBADDR_BW
`define QBADDR_BW 4
`endif
`ifndef NUM_PQ
`define NUM_PQ 16
`endif

module psu_maskacc #(
   parameter int UC_STEPS = `NUM_UCDMX_OUT,
   parameter int QB_STEPS = `NUM_QBDMX_OUT,
   parameter int STEP_BW  = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start_valid,
   output logic                                start_ready,
   output logic                                sweep_busy,
   output logic [`NUM_UCC*`UCADDR_BW-1:0]      uc_counter,
   output logic [`NUM_QBCTRL*`QBADDR_BW-1:0]   qb_counter,
   input  logic [`NUM_PQ-1:0]                  mask_ext_array,
   input  logic [`NUM_PQ-1:0]                  special_ext_array,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [`NUM_PQ-1:0]                  out_mask,
   output logic [`NUM_PQ-1:0]                  out_special,
   output logic                                collision
);
   localparam logic [1:0] S_IDLE = 2'd0, S_SWEEP = 2'd1, S_HOLD = 2'd2;
   localparam int UCB = `UCADDR_BW;
   localparam int QBB = `QBADDR_BW;
   logic [1:0]         r_state;
   logic [STEP_BW-1:0] r_uc, r_qb;
   logic [`NUM_PQ-1:0] r_mask, r_special;
   logic               w_qb_last, w_last;
   assign w_qb_last   = r_qb == STEP_BW'(QB_STEPS - 1);
   assign w_last      = w_qb_last && r_uc == STEP_BW'(UC_STEPS - 1);
   assign start_ready = r_state == S_IDLE;
   assign sweep_busy  = r_state == S_SWEEP;
   assign out_valid   = r_state == S_HOLD;
   assign out_mask    = r_mask;
   assign out_special = r_special;
   for (genvar j = 0; j < `NUM_UCC; j++) begin : g_uc
      assign uc_counter[j*UCB +: UCB] = UCB'(j + int'(r_uc) * `NUM_UCC);
   end
   for (genvar k = 0; k < `NUM_QBCTRL; k++) begin : g_qb
      assign qb_counter[k*QBB +: QBB] = QBB'(k + int'(r_qb) * `NUM_QBCTRL);
   end
   // qb is the inner loop; both steps wrap to 0 on the last slot so IDLE/HOLD present step 0
   always_ff @(posedge clk)
      if (!rst) begin
         r_state   <= S_IDLE;
         r_uc      <= '0;
         r_qb      <= '0;
         r_mask    <= '0;
         r_special <= '0;
      end else if (r_state == S_IDLE) begin
         if (start_valid) begin
            r_state   <= S_SWEEP;
            r_mask    <= '0;
            r_special <= '0;
         end
      end else if (r_state == S_SWEEP) begin
         r_mask    <= r_mask | mask_ext_array;
         r_special <= r_special | special_ext_array;
         r_qb      <= w_qb_last ? '0 : r_qb + 1'b1;
         r_uc      <= w_last ? '0 : w_qb_last ? r_uc + 1'b1 : r_uc;
         r_state   <= w_last ? S_HOLD : S_SWEEP;
      end else if (out_ready)
         r_state <= S_IDLE;
`ifdef PSU_MASKACC_COLLISION_EN
   logic r_coll;
   always_ff @(posedge clk)
      if (!rst || (start_ready && start_valid))
         r_coll <= 1'b0;
      else if (sweep_busy && (|(r_mask & mask_ext_array) || |(r_special & special_ext_array)))
         r_coll <= 1'b1;
   assign collision = r_coll;
`else
   assign collision = 1'b0;
`endif
endmodule
